// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Build macro PIPE_HAZARD_CTRL_PERF_EN enables the stall/flush counters in the top.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    DRAIN,
    HALT
  } hazard_state_t;

  localparam int MUL_LATENCY_DEF  = 4;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W            = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose rd feeds a source of the
// instruction in ID. Kept standalone so forwarding logic can reuse it.
module hazard_detect (
  input  logic [4:0] i_ra_idx,
  input  logic [4:0] i_rb_idx,
  input  logic       i_uses_ra,
  input  logic       i_uses_rb,
  input  logic [4:0] i_ex_dest_idx,
  input  logic       i_ex_rd_mem,
  output logic       o_load_use
);

  logic w_ra_hit;
  logic w_rb_hit;

  assign w_ra_hit   = i_uses_ra && (i_ra_idx == i_ex_dest_idx);
  assign w_rb_hit   = i_uses_rb && (i_rb_idx == i_ex_dest_idx);
  // x0 is hard-wired to zero, so a load targeting it never produces a hazard.
  assign o_load_use = i_ex_rd_mem && (i_ex_dest_idx != 5'd0) && (w_ra_hit || w_rb_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble/flush control for the 5-stage core: load-use, MUL hold,
// branch flush and EBREAK drain-and-halt. Define PIPE_HAZARD_CTRL_PERF_EN for perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY  = MUL_LATENCY_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_inst,
  input  logic [4:0]  id_ra_idx,
  input  logic [4:0]  id_rb_idx,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_is_mul,
  input  logic        id_is_ebreak,
  input  logic [4:0]  id_ex_dest_reg_idx,
  input  logic        id_ex_rd_mem,
  input  logic        ex_take_branch,
  output logic        if_stall,
  output logic        id_stall,
  output logic        id_ex_bubble,
  output logic        ex_hold,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mul_busy,
  output logic        halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_out,
  output logic [31:0] flush_count_out
`endif
);

  localparam logic [CNT_W-1:0] MUL_INIT   = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

  hazard_state_t    r_state;
  hazard_state_t    w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_load_use;
  logic             w_issue;

  hazard_detect u_hazard_detect (
    .i_ra_idx      (id_ra_idx),
    .i_rb_idx      (id_rb_idx),
    .i_uses_ra     (id_uses_ra),
    .i_uses_rb     (id_uses_rb),
    .i_ex_dest_idx (id_ex_dest_reg_idx),
    .i_ex_rd_mem   (id_ex_rd_mem),
    .o_load_use    (w_load_use)
  );

  assign w_issue = id_valid_inst && !w_load_use && !ex_take_branch;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_issue && id_is_mul && (MUL_LATENCY > 1)) begin
          w_next_state = MUL_WAIT;
          w_next_cnt   = MUL_INIT;
        end else if (w_issue && id_is_ebreak) begin
          w_next_state = DRAIN;
          w_next_cnt   = DRAIN_INIT;
        end
      end
      MUL_WAIT: begin
        if (r_cnt == '0) w_next_state = RUN;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      DRAIN: begin
        if (r_cnt == '0) w_next_state = HALT;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      HALT:    w_next_state = HALT;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mul_busy     = 1'b0;
    halted       = 1'b0;
    case (r_state)
      RUN: begin
        // A taken branch squashes the dependent instruction, so its load-use stall is moot.
        if (ex_take_branch) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          if_stall     = 1'b1;
          id_stall     = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      MUL_WAIT: begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_hold  = 1'b1;
        mul_busy = 1'b1;
      end
      DRAIN: begin
        if_stall     = 1'b1;
        id_stall     = 1'b1;
        id_ex_bubble = 1'b1;
      end
      HALT: begin
        if_stall     = 1'b1;
        id_stall     = 1'b1;
        id_ex_bubble = 1'b1;
        halted       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (if_stall && (r_state != HALT) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (ex_take_branch && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles_out = r_stall_cycles;
  assign flush_count_out  = r_flush_count;
`endif

endmodule
